// File: rtl/count_ctrl.sv
// Button-driven direction/pause controller for a reversible counter.
// Synchronizes and debounces three buttons and emits a prescaled step-enable.
module count_ctrl #(
  parameter int unsigned DIV = 4,
  parameter int unsigned DEB = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_pause,
  output logic en,
  output logic dir,
  output logic paused
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int unsigned NB = 3;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_PAUSE = 2;

  typedef enum logic [1:0] {
    RUN_UP     = 2'd0,
    RUN_DOWN   = 2'd1,
    PAUSE_UP   = 2'd2,
    PAUSE_DOWN = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NB-1:0]          meta;
  logic [NB-1:0]          sync;
  logic [NB-1:0]          db;
  logic [NB-1:0][CW-1:0]  cnt;
  logic [NB-1:0][CW-1:0]  cnt_nxt;
  logic [NB-1:0]          flip;
  logic [NB-1:0]          press;
  logic [PW-1:0]          pre;
  logic [PW-1:0]          pre_nxt;
  logic                   en_nxt;
  logic                   cur_up;
  logic                   cur_pause;
  logic                   nxt_up;
  logic                   nxt_pause;
  logic                   dir_chg;

  // Debounce: db follows sync once it has disagreed for DEB consecutive edges.
  always_comb begin
    flip    = '0;
    press   = '0;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      flip[i]  = (sync[i] != db[i]) && (cnt[i] == CW'(DEB - 1));
      press[i] = flip[i] & sync[i];
      if ((sync[i] == db[i]) || flip[i]) begin
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Control decisions act on presses in the same edge that db updates.
  always_comb begin
    cur_up    = (state == RUN_UP) || (state == PAUSE_UP);
    cur_pause = (state == PAUSE_UP) || (state == PAUSE_DOWN);
    nxt_up    = cur_up;
    if (press[B_UP] && !press[B_DOWN]) begin
      nxt_up = 1'b1;
    end else if (press[B_DOWN] && !press[B_UP]) begin
      nxt_up = 1'b0;
    end
    nxt_pause = cur_pause ^ press[B_PAUSE];
    dir_chg   = nxt_up != cur_up;
    case ({nxt_pause, nxt_up})
      2'b01:   state_nxt = RUN_UP;
      2'b00:   state_nxt = RUN_DOWN;
      2'b11:   state_nxt = PAUSE_UP;
      default: state_nxt = PAUSE_DOWN;
    endcase
  end

  // Prescaler restarts on a direction change so en never coincides with it.
  always_comb begin
    pre_nxt = pre;
    en_nxt  = 1'b0;
    if (dir_chg) begin
      pre_nxt = '0;
    end else if (!cur_pause) begin
      if (pre == PW'(DIV - 1)) begin
        pre_nxt = '0;
        en_nxt  = 1'b1;
      end else begin
        pre_nxt = pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= '0;
      sync   <= '0;
      db     <= '0;
      cnt    <= '0;
      pre    <= '0;
      en     <= 1'b0;
      state  <= RUN_UP;
      dir    <= 1'b1;
      paused <= 1'b0;
    end else begin
      meta   <= {btn_pause, btn_down, btn_up};
      sync   <= meta;
      db     <= db ^ flip;
      cnt    <= cnt_nxt;
      pre    <= pre_nxt;
      en     <= en_nxt;
      state  <= state_nxt;
      dir    <= nxt_up;
      paused <= nxt_pause;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios plus random button
// activity, compared every cycle against a behavioural model.
module tb_count_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DEB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_pause = 1'b0;
  logic en;
  logic dir;
  logic paused;

  int n_checks = 0;
  int n_errs = 0;

  // Model state: raw samples delayed two edges, debounced level and the
  // length of the current disagreement run, plus control outputs.
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_db [3];
  int m_run [3];
  bit m_dir;
  bit m_paused;
  bit m_en;
  int m_ticks;

  always #5 clk = ~clk;

  count_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_pause (btn_pause),
    .en        (en),
    .dir       (dir),
    .paused    (paused)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_run[b] = 0;
    end
    m_dir = 1; m_paused = 0; m_en = 0; m_ticks = 0;
  endtask

  task automatic model_step();
    bit pressed [3];
    bit raw [3];
    bit new_dir;
    bit was_paused;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_pause;
    for (int b = 0; b < 3; b++) begin
      pressed[b] = 0;
      if (m_s2[b] != m_db[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == int'(DEB)) begin
          m_db[b] = m_s2[b];
          m_run[b] = 0;
          pressed[b] = m_db[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    new_dir = m_dir;
    if (pressed[0] && !pressed[1]) new_dir = 1;
    if (pressed[1] && !pressed[0]) new_dir = 0;
    was_paused = m_paused;
    m_paused = m_paused ^ pressed[2];
    if (new_dir != m_dir) begin
      m_ticks = 0;
      m_en = 0;
    end else if (!was_paused) begin
      m_ticks = (m_ticks + 1) % int'(DIV);
      m_en = (m_ticks == 0);
    end else begin
      m_en = 0;
    end
    m_dir = new_dir;
  endtask

  task automatic step(input logic r, input logic u, input logic d, input logic p);
    @(negedge clk);
    rst_n = r; btn_up = u; btn_down = d; btn_pause = p;
    @(posedge clk);
    model_step();
    #1;
    check("en", en, m_en);
    check("dir", dir, m_dir);
    check("paused", paused, m_paused);
  endtask

  initial begin
    logic r, u, d, p;
    int len;
    model_reset();

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_en", en, 1'b0);
    check("rst_dir", dir, 1'b1);
    check("rst_paused", paused, 1'b0);

    // Steady cadence after release: en after edges DIV, 2*DIV, ...
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0);
      check("cadence", en, (k % int'(DIV)) == 0);
    end

    // Held down press flips direction at edge DEB+2 with en low
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 1, 0);
      if (k == 5) begin
        check("down_dir", dir, 1'b0);
        check("down_en", en, 1'b0);
      end
      if (k == 4) check("down_dir_early", dir, 1'b1);
    end
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);

    // Back to up, then a 2-cycle glitch on down must be ignored
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    check("up_dir", dir, 1'b1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0);
      check("glitch_dir", dir, 1'b1);
    end

    // Pause, hold, resume
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    check("pause_on", paused, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0);
      check("pause_en", en, 1'b0);
    end
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    check("pause_off", paused, 1'b0);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0);

    // Simultaneous up+down while counting down keeps direction
    for (int k = 0; k < 8; k++) step(1, 0, 1, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 1, 1, 0);
    check("both_dir", dir, 1'b0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);

    // Reset while PAUSE_DOWN
    for (int k = 0; k < 6; k++) step(1, 0, 0, 1);
    check("pd_paused", paused, 1'b1);
    check("pd_dir", dir, 1'b0);
    step(0, 0, 0, 1);
    check("rst2_dir", dir, 1'b1);
    check("rst2_paused", paused, 1'b0);
    check("rst2_en", en, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0, 0);
      check("rst2_cadence", en, (k % int'(DIV)) == 0);
    end

    // Random button activity with occasional reset
    for (int seg = 0; seg < 400; seg++) begin
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 59) != 0);
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) step(r, u, d, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DIV, default 4, prescaler ratio: cycles between enable pulses (legal range 1..1024).
REQ-002 Parameter DEB, default 3, debounce length in cycles (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 btn_up  input  1  asynchronous raw button; a press selects up-counting.
REQ-006 btn_down  input  1  asynchronous raw button; a press selects down-counting.
REQ-007 btn_pause  input  1  asynchronous raw button; a press toggles pause.
REQ-008 en  output  1  registered one-cycle step-enable pulse to the downstream reversible counter.
REQ-009 dir  output  1  registered count direction: 1 = up, 0 = down.
REQ-010 paused  output  1  registered pause status: 1 = paused.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-012 Each synchronized button SHALL drive its own debouncer with a level register db and a counter cnt.
REQ-013 Debouncer, sync == db: cnt <= 0.
REQ-014 Debouncer, sync != db and cnt < DEB-1: cnt <= cnt+1.
REQ-015 Debouncer, sync != db and cnt == DEB-1: db <= sync and cnt <= 0.
REQ-016 A raw level held stable SHALL reach db on the (DEB+2)th rising edge after it changes.
REQ-017 A synchronized glitch shorter than DEB cycles SHALL leave db unchanged.
REQ-018 A press event is db going 0->1; the press SHALL take effect on the same edge db updates, i.e. edge DEB+2.
REQ-019 Control FSM states: RUN_UP, RUN_DOWN, PAUSE_UP, PAUSE_DOWN.
REQ-020 FSM output decode: dir = 1 in the *_UP states; paused = 1 in the PAUSE_* states.
REQ-021 up press: RUN_DOWN->RUN_UP and PAUSE_DOWN->PAUSE_UP; no change if dir is already 1.
REQ-022 down press: RUN_UP->RUN_DOWN and PAUSE_UP->PAUSE_DOWN; no change if dir is already 0.
REQ-023 up and down pressed on the same edge: direction SHALL be unchanged.
REQ-024 pause press: RUN_x<->PAUSE_x with the same x; it SHALL be applied together with any direction press on that edge.
REQ-025 Prescaler pre: width max(1, clog2(DIV)); counts 0..DIV-1 then wraps to 0, advancing only in RUN_* states.
REQ-026 In PAUSE_* states pre SHALL hold its value and en SHALL be 0; on resume pre continues from the held value.
REQ-027 en SHALL be 1 for exactly the cycle after an edge at which pre == DIV-1 in a RUN state with no direction change.
REQ-028 Steady running: en pulses every DIV cycles; with DIV = 1, en stays high continuously.
REQ-029 On an edge where dir changes, pre <= 0 and en <= 0, so the next pulse comes DIV cycles later in the new direction.
REQ-030 dir SHALL never change in the same cycle that en is high; the downstream counter samples a stable direction.

Reset
REQ-031 While rst_n = 0 at a rising edge, all registers SHALL clear: synchronizers 0, db 0, cnt 0, pre 0.
REQ-032 The same reset edge SHALL set the outputs and FSM: en 0, state RUN_UP (dir 1, paused 0).
REQ-033 Reset asserted mid-operation (including mid-debounce or paused) SHALL override every other update on that edge.
REQ-034 The first en after rst_n rises SHALL occur in the cycle after the DIV-th rising edge sampling rst_n = 1.

Verification (DIV = 4, DEB = 3, buttons low unless stated)
REQ-035 Reset release, no buttons -> en high on cycles 4, 8, 12, ... after release; dir = 1; paused = 0.
REQ-036 btn_down high, held for 10 cycles -> dir = 0 at edge 5, en low that cycle, next en 4 cycles later.
REQ-037 btn_down high 2 cycles, then low -> dir stays 1; en cadence undisturbed.
REQ-038 btn_pause press at pre = 2 -> paused = 1, en stays 0.
REQ-039 Second btn_pause press -> paused = 0; first en 2 cycles after resume.
REQ-040 btn_up and btn_down rise together while dir = 0 -> dir stays 0.
REQ-041 rst_n driven low for 1 cycle while PAUSE_DOWN -> next cycle: dir = 1, paused = 0, en = 0, pre = 0.
